// File: rtl/soc_system_led_pio_ctrl_pkg.sv
// Shared types for the LED PIO controller: FSM states, requester ids, PIO register map.
// No logic, no latency.
// Imported by the controller top and its testbench.
package soc_system_led_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2
    } state_e;

    typedef enum logic {
        SRC_HOST = 1'b0,
        SRC_AUTO = 1'b1
    } src_e;

    // The PIO exposes its data register at word address 0.
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;

endpackage

// File: rtl/soc_system_led_pio_ctrl_if.sv
// Avalon-MM bus to the LED PIO slave s1.
// Signals: address, chipselect, write_n (active-low), writedata, readdata.
// Zero wait states: readdata is combinational from the slave, there is no waitrequest.
interface soc_system_led_pio_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_led_pio_ctrl_tick_gen.sv
// Heartbeat generator: emits one tick every TICK_DIV cycles while auto_en, and rotates a walking-one pattern.
// Ports: clk, reset (sync, active-high), auto_en in; tick (1-cycle pulse), pattern (LED_W bits) out.
// No backpressure: ticks are never held off; coalescing is done by the consumer.
module soc_system_led_tick_gen #(
    parameter int LED_W    = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             auto_en,
    output logic             tick,
    output logic [LED_W-1:0] pattern
);
    localparam int              CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LED_W-1:0] pattern_q, pattern_d;

    always_comb begin
        tick      = auto_en && (cnt_q == CNT_MAX);
        cnt_d     = '0;
        pattern_d = pattern_q;
        if (auto_en && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Rotate left within LED_W bits; the shift pair also covers LED_W == 1.
        if (tick) begin
            pattern_d = (pattern_q << 1) | (pattern_q >> (LED_W - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pattern_q <= LED_W'(1);
        end else begin
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
        end
    end

    assign pattern = pattern_q;

endmodule

// File: rtl/soc_system_led_pio_ctrl.sv
// LED PIO write master shared by a host request port and the heartbeat; every write is read back once.
// Ports: clk, reset; host_req/host_data/host_ack; auto_en; busy; mismatch/mismatch_clr; pio (Avalon master).
// Latency 3 cycles per transaction (grant, write, verify); host waits while busy, held request is the backpressure.
module soc_system_led_pio_ctrl
    import soc_system_led_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LED_W    = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       host_req,
    input  logic [DATA_W-1:0]          host_data,
    output logic                       host_ack,
    input  logic                       auto_en,
    output logic                       busy,
    output logic                       mismatch,
    input  logic                       mismatch_clr,
    soc_system_led_pio_ctrl_if.master  pio
);
    logic             tick;
    logic [LED_W-1:0] pattern;

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    src_e              last_src_q, last_src_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              auto_pend_q, auto_pend_d;
    logic              mismatch_q, mismatch_d;
    logic              cs_q, cs_d;
    logic              write_n_q, write_n_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              grant_auto;
    logic              mismatch_set;

    soc_system_led_tick_gen #(
        .LED_W    (LED_W),
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .auto_en (auto_en),
        .tick    (tick),
        .pattern (pattern)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        last_src_d   = last_src_q;
        wr_data_d    = wr_data_q;
        grant_auto   = 1'b0;
        mismatch_set = 1'b0;
        host_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (auto_pend_q && (!host_req || last_src_q == SRC_HOST)) begin
                    grant_auto = 1'b1;
                    src_d      = SRC_AUTO;
                    last_src_d = SRC_AUTO;
                    wr_data_d  = DATA_W'(pattern);
                    state_d    = WRITE;
                end else if (host_req) begin
                    src_d      = SRC_HOST;
                    last_src_d = SRC_HOST;
                    wr_data_d  = host_data;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                mismatch_set = (pio.readdata != wr_data_q);
                host_ack     = (src_q == SRC_HOST);
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A tick in the grant cycle re-arms the request (set wins over clear).
        auto_pend_d = auto_en && (tick || (auto_pend_q && !grant_auto));
        mismatch_d  = mismatch_set || (mismatch_q && !mismatch_clr);

        // Bus outputs are registered from the next state so they line up with WRITE/VERIFY.
        cs_d        = (state_d != IDLE);
        write_n_d   = (state_d != WRITE);
        writedata_d = (state_d == WRITE) ? wr_data_d : writedata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= SRC_HOST;
            last_src_q  <= SRC_HOST;
            wr_data_q   <= '0;
            auto_pend_q <= 1'b0;
            mismatch_q  <= 1'b0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            last_src_q  <= last_src_d;
            wr_data_q   <= wr_data_d;
            auto_pend_q <= auto_pend_d;
            mismatch_q  <= mismatch_d;
            cs_q        <= cs_d;
            write_n_q   <= write_n_d;
            writedata_q <= writedata_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign mismatch       = mismatch_q;
    assign pio.address    = PIO_ADDR_DATA;
    assign pio.chipselect = cs_q;
    assign pio.write_n    = write_n_q;
    assign pio.writedata  = writedata_q;

endmodule

// File: tb/tb_soc_system_led_pio_ctrl.sv
// Testbench for soc_system_led_pio_ctrl with a behavioural LED PIO slave (reset value 0x0000FFFF).
// A transaction-level reference model runs alongside every cycle; directed tables and sequences add targeted checks.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
module tb_soc_system_led_pio_ctrl;
    localparam int DATA_W   = 32;
    localparam int LED_W    = 8;
    localparam int TICK_DIV = 4;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        host_req     = 1'b0;
    logic [31:0] host_data    = '0;
    logic        auto_en      = 1'b0;
    logic        mismatch_clr = 1'b0;
    logic        force_rd     = 1'b0;
    logic        host_ack, busy, mismatch;
    logic [31:0] pio_reg;

    int errors = 0;
    int checks = 0;

    soc_system_led_pio_ctrl_if #(.DATA_W(DATA_W)) pio_bus ();

    soc_system_led_pio_ctrl #(
        .DATA_W   (DATA_W),
        .LED_W    (LED_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_req     (host_req),
        .host_data    (host_data),
        .host_ack     (host_ack),
        .auto_en      (auto_en),
        .busy         (busy),
        .mismatch     (mismatch),
        .mismatch_clr (mismatch_clr),
        .pio          (pio_bus)
    );

    always #5 clk = ~clk;

    // LED PIO slave: one data register, zero-wait combinational read.
    always @(posedge clk) begin
        if (reset) pio_reg <= 32'h0000FFFF;
        else if (pio_bus.chipselect && !pio_bus.write_n && pio_bus.address == 2'd0)
            pio_reg <= pio_bus.writedata;
    end
    assign pio_bus.readdata = force_rd ? 32'h0 : pio_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Heartbeat modelled as a step count (pattern = 1 << steps mod LED_W); a transaction
    // is "cycles elapsed since grant" (0 = none in flight, 1 = write cycle, 2 = readback cycle).
    bit          m_live = 0;
    int          m_cnt, m_steps, m_age;
    bit          m_pend, m_src_auto, m_last_auto, m_mis;
    logic [31:0] m_data, m_wd, m_pio, m_rd;
    bit          m_tick, m_g_host, m_g_auto;

    function automatic logic [31:0] pat(input int steps);
        logic [31:0] one;
        one = 32'd1;
        return one << (steps % LED_W);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1; m_cnt = 0; m_steps = 0; m_age = 0; m_pend = 0;
            m_src_auto = 0; m_last_auto = 0; m_mis = 0; m_data = '0; m_wd = '0;
            m_pio = 32'h0000FFFF;
        end else begin
            m_tick   = auto_en && (m_cnt == TICK_DIV - 1);
            m_g_host = 0;
            m_g_auto = 0;
            if (m_age == 0) begin
                if (host_req && m_pend) begin
                    if (m_last_auto) m_g_host = 1; else m_g_auto = 1;
                end else if (host_req) m_g_host = 1;
                else if (m_pend)      m_g_auto = 1;
            end
            if (m_age == 2) begin
                m_rd = force_rd ? 32'h0 : m_pio;
                if (m_rd != m_data)    m_mis = 1;
                else if (mismatch_clr) m_mis = 0;
            end else if (mismatch_clr) m_mis = 0;
            if (m_age == 1) m_pio = m_data;
            if (m_g_host || m_g_auto) begin
                m_data      = m_g_host ? host_data : pat(m_steps);
                m_wd        = m_data;
                m_src_auto  = m_g_auto;
                m_last_auto = m_g_auto;
                m_age       = 1;
            end else if (m_age != 0) begin
                m_age = (m_age + 1) % 3;
            end
            m_pend = auto_en && (m_tick || (m_pend && !m_g_auto));
            m_cnt  = auto_en ? (m_cnt + 1) % TICK_DIV : 0;
            if (m_tick) m_steps++;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_busy",     busy,                 32'(m_age != 0));
            chk("model_cs",       pio_bus.chipselect,   32'(m_age != 0));
            chk("model_write_n",  pio_bus.write_n,      32'(m_age != 1));
            chk("model_address",  pio_bus.address,      32'd0);
            chk("model_wdata",    pio_bus.writedata,    m_wd);
            chk("model_host_ack", host_ack,             32'(m_age == 2 && !m_src_auto));
            chk("model_mismatch", mismatch,             32'(m_mis));
            chk("model_pio_reg",  pio_reg,              m_pio);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1; host_req = 0; auto_en = 0; force_rd = 0; mismatch_clr = 0;
        cyc(); cyc();
        reset = 0;
    endtask

    // Cycle 1 is the cycle the request is first presented; ack cycle and first write cycle are checked.
    task automatic host_write(input logic [31:0] d, input bit frc, input int exp_lat,
                              input logic [31:0] exp_first, input string tag);
        int lat, wcyc;
        bit seen;
        logic [31:0] first;
        lat = 99; wcyc = 99; seen = 0; first = '0;
        host_data = d; host_req = 1; force_rd = frc;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (!seen && pio_bus.chipselect && !pio_bus.write_n) begin
                seen = 1; first = pio_bus.writedata; wcyc = i + 1;
            end
            if (host_ack) begin
                lat = i + 1;
                break;
            end
        end
        host_req = 0;
        cyc();
        force_rd = 0;
        chk({tag, "_ack_cycle"},   32'(lat),  32'(exp_lat));
        chk({tag, "_write_cycle"}, 32'(wcyc), 32'd2);
        chk({tag, "_first_data"},  first,     exp_first);
        chk({tag, "_pio"},         pio_reg,   d);
    endtask

    typedef struct {
        logic [31:0] data;
        bit          frc;
        bit          clr;
        bit          exp_mis;
    } vec_t;

    vec_t        vt[5];
    logic [31:0] wr_seen[16];
    int          wr_cyc[16];
    int          nwr, nack, n;

    initial begin
        vt[0] = '{32'h000000A5, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'h0000003C, 1'b1, 1'b0, 1'b1};
        vt[2] = '{32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vt[3] = '{32'h00000000, 1'b0, 1'b1, 1'b0};
        vt[4] = '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        // 1. reset state: bus idle, PIO keeps its own reset value
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst_cs", pio_bus.chipselect, 32'd0);
            chk("rst_write_n", pio_bus.write_n, 32'd1);
            chk("rst_busy", busy, 32'd0);
            chk("rst_pio", pio_reg, 32'h0000FFFF);
            chk("rst_mismatch", mismatch, 32'd0);
        end

        // host write table, including forced readback failure, sticky flag and clear
        foreach (vt[i]) begin
            if (vt[i].clr) begin
                mismatch_clr = 1;
                cyc();
                mismatch_clr = 0;
                chk("clr_mismatch", mismatch, 32'd0);
            end
            host_write(vt[i].data, vt[i].frc, 3, vt[i].data, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_mismatch", i), mismatch, 32'(vt[i].exp_mis));
        end

        // 2. heartbeat alone for 40 cycles
        do_reset();
        auto_en = 1; nwr = 0; nack = 0;
        for (int i = 1; i <= 45; i++) begin
            cyc();
            if (i == 40) auto_en = 0;
            if (pio_bus.chipselect && !pio_bus.write_n && nwr < 16) begin
                wr_seen[nwr] = pio_bus.writedata; wr_cyc[nwr] = i; nwr++;
            end
            if (host_ack) nack++;
        end
        chk("hb_enough_writes", 32'(nwr >= 9), 32'd1);
        chk("hb_no_ack", 32'(nack), 32'd0);
        for (int i = 0; i < 9 && i < nwr; i++) begin
            chk($sformatf("hb_value%0d", i), wr_seen[i], pat(i + 1));
            if (i > 0) chk($sformatf("hb_gap%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd4);
        end

        // 3. tie with last served = HOST: AUTO first, host ack 6 cycles later
        do_reset();
        host_write(32'h00000011, 0, 3, 32'h00000011, "tie_pre");
        auto_en = 1;
        n = 0;
        while (!m_pend && n < 40) begin cyc(); n++; end
        chk("tie1_wait", 32'(n < 40), 32'd1);
        host_write(32'h00000055, 0, 6, pat(1), "tie1");
        // after an AUTO-only write, the next tie goes to HOST
        n = 0;
        while (!(m_age == 1 && m_src_auto) && n < 40) begin cyc(); n++; end
        chk("tie2_wait_auto", 32'(n < 40), 32'd1);
        n = 0;
        while (!(m_pend && m_age == 0) && n < 40) begin cyc(); n++; end
        chk("tie2_wait_pend", 32'(n < 40), 32'd1);
        host_write(32'h00000066, 0, 3, 32'h00000066, "tie2");
        auto_en = 0;

        // 5. reset during WRITE abandons the transaction
        do_reset();
        host_data = 32'h00000077; host_req = 1;
        cyc();
        chk("rw_in_write_cs", pio_bus.chipselect, 32'd1);
        chk("rw_in_write_wn", pio_bus.write_n, 32'd0);
        reset = 1;
        cyc();
        chk("rw_cs", pio_bus.chipselect, 32'd0);
        chk("rw_write_n", pio_bus.write_n, 32'd1);
        chk("rw_busy", busy, 32'd0);
        chk("rw_ack", host_ack, 32'd0);
        reset = 0; host_req = 0;
        cyc();
        host_write(32'h00000077, 0, 3, 32'h00000077, "rw_retry");

        // 6. auto_en dropped the cycle after an AUTO grant
        do_reset();
        auto_en = 1;
        n = 0;
        while (!(m_age == 1) && n < 40) begin cyc(); n++; end
        chk("drop_wait", 32'(n < 40), 32'd1);
        auto_en = 0;
        chk("drop_wdata", pio_bus.writedata, 32'h00000002);
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (pio_bus.chipselect && !pio_bus.write_n) nwr++;
        end
        chk("drop_no_more_writes", 32'(nwr), 32'd0);
        chk("drop_pio", pio_reg, 32'h00000002);
        chk("drop_cnt", 32'(dut.u_tick.cnt_q), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cyc();
            if (host_req && host_ack) host_req = 0;
            else if (!host_req && $urandom_range(0, 3) == 0) begin
                host_req = 1; host_data = $urandom;
            end
            if ($urandom_range(0, 29) == 0) auto_en = !auto_en;
            force_rd     = ($urandom_range(0, 7) == 0);
            mismatch_clr = ($urandom_range(0, 9) == 0);
            if (reset) reset = 0;
            else if ($urandom_range(0, 199) == 0) begin
                reset = 1; host_req = 0;
            end
        end
        reset = 0; host_req = 0; auto_en = 0; force_rd = 0; mismatch_clr = 0;
        cyc(); cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
